// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the multi-channel data synchroniser.
package data_sync_pkg;

    localparam int MODE_LEVEL     = 0;
    localparam int MODE_TOGGLE    = 1;
    localparam int NUM_STAGES_MIN = 2;
    localparam int NUM_STAGES_MAX = 4;

    // Channel index width; a single channel still needs a 1-bit field.
    function automatic int chw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_sync_bit_sync.sv
// Single-bit multi-flop synchroniser with synchronous reset.
module bit_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] s;

    always_ff @(posedge CLK) begin
        if (RST) s <= '0;
        else     s <= {s[NUM_STAGES-2:0], d};
    end

    assign q = s[NUM_STAGES-1];

endmodule

// File: rtl/multi_chan_data_sync.sv
// Multi-channel enable-qualified data synchroniser with round-robin merge.
// Optional macro DATA_SYNC_ACK_EN adds per-channel sync_ack toggle outputs.
module multi_chan_data_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = MODE_LEVEL,
    localparam int CHW        = chw_f(NUM_CH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [BUS_WIDTH-1:0]        sync_bus,
    output logic [CHW-1:0]              sync_chan,
    output logic                        sync_valid,
    input  logic                        sync_ready,
    output logic                        enable_pulse,
    output logic [NUM_CH-1:0]           pending,
    output logic [NUM_CH-1:0]           overrun,
    input  logic [NUM_CH-1:0]           ovr_clr
`ifdef DATA_SYNC_ACK_EN
    ,
    output logic [NUM_CH-1:0]           sync_ack
`endif
);

    if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
        $error("NUM_STAGES out of range");
    end

    logic [NUM_CH-1:0]    synced;
    logic [NUM_CH-1:0]    prev;
    logic [NUM_CH-1:0]    evt;
    logic [NUM_CH-1:0]    grant_vec;
    logic [BUS_WIDTH-1:0] hold [NUM_CH];
    logic [CHW-1:0]       rr_ptr;
    logic [CHW-1:0]       grant_idx;
    logic                 grant_any;
    logic                 load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
        bit_sync #(.NUM_STAGES(NUM_STAGES)) u_bit_sync (
            .CLK (CLK),
            .RST (RST),
            .d   (bus_enable[c]),
            .q   (synced[c])
        );
    end

    assign evt = (TOGGLE_MODE == MODE_TOGGLE) ? (synced ^ prev) : (synced & ~prev);

    assign load = !sync_valid || sync_ready;

    // Search starts one past the last granted channel so every channel gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!grant_any && pending[idx]) begin
                grant_any = 1'b1;
                grant_idx = CHW'(idx);
            end
        end
    end

    assign grant_vec = (load && grant_any) ? (NUM_CH'(1) << grant_idx) : '0;

    // A grant and a new event on the same channel keep pending set without overrun.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev    <= '0;
            pending <= '0;
            overrun <= '0;
            for (int c = 0; c < NUM_CH; c++) hold[c] <= '0;
        end else begin
            prev    <= synced;
            pending <= (pending & ~grant_vec) | evt;
            overrun <= (overrun & ~ovr_clr) | (evt & pending & ~grant_vec);
            for (int c = 0; c < NUM_CH; c++) begin
                if (evt[c]) hold[c] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_bus     <= '0;
            sync_chan    <= '0;
            sync_valid   <= 1'b0;
            enable_pulse <= 1'b0;
            rr_ptr       <= CHW'(NUM_CH - 1);
        end else begin
            enable_pulse <= 1'b0;
            if (load) begin
                if (grant_any) begin
                    sync_bus     <= hold[grant_idx];
                    sync_chan    <= grant_idx;
                    sync_valid   <= 1'b1;
                    enable_pulse <= 1'b1;
                    rr_ptr       <= grant_idx;
                end else begin
                    sync_valid   <= 1'b0;
                end
            end
        end
    end

`ifdef DATA_SYNC_ACK_EN
    always_ff @(posedge CLK) begin
        if (RST) sync_ack <= '0;
        else     sync_ack <= sync_ack ^ grant_vec;
    end
`endif

endmodule

// File: tb/tb_multi_chan_data_sync.sv
// Bench for multi_chan_data_sync: one level-mode and one toggle-mode instance.
module tb_multi_chan_data_sync;

    localparam int NS = 2;
    localparam int BW = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst;
    logic [1:0][31:0]    bus;
    logic [1:0][3:0]     en;
    logic [1:0][3:0]     clr;
    logic [1:0]          rdy;
    logic [1:0][7:0]     sb;
    logic [1:0][1:0]     sc;
    logic [1:0]          valid;
    logic [1:0]          pulse;
    logic [1:0][3:0]     pend;
    logic [1:0][3:0]     ovr;
`ifdef DATA_SYNC_ACK_EN
    logic [1:0][3:0]     ack;
`endif

    multi_chan_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(0)) u_lvl (
        .CLK(clk), .RST(rst[0]), .unsync_bus(bus[0]), .bus_enable(en[0]),
        .sync_bus(sb[0]), .sync_chan(sc[0]), .sync_valid(valid[0]), .sync_ready(rdy[0]),
        .enable_pulse(pulse[0]), .pending(pend[0]), .overrun(ovr[0]), .ovr_clr(clr[0])
`ifdef DATA_SYNC_ACK_EN
        , .sync_ack(ack[0])
`endif
    );

    multi_chan_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(1)) u_tgl (
        .CLK(clk), .RST(rst[1]), .unsync_bus(bus[1]), .bus_enable(en[1]),
        .sync_bus(sb[1]), .sync_chan(sc[1]), .sync_valid(valid[1]), .sync_ready(rdy[1]),
        .enable_pulse(pulse[1]), .pending(pend[1]), .overrun(ovr[1]), .ovr_clr(clr[1])
`ifdef DATA_SYNC_ACK_EN
        , .sync_ack(ack[1])
`endif
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model state: enable history per channel, holding regs, output register.
    int m_hist [2][NC][NS+1];
    int m_pend [2][NC];
    int m_ovr  [2][NC];
    int m_hold [2][NC];
    int m_valid[2];
    int m_pulse[2];
    int m_bus  [2];
    int m_chan [2];
    int m_ptr  [2];

    task automatic model_step(input int m);
        int evt[NC];
        int g;
        int sy;
        int pv;
        int c;
        if (rst[m]) begin
            for (int k = 0; k < NC; k++) begin
                m_pend[m][k] = 0;
                m_ovr[m][k]  = 0;
                m_hold[m][k] = 0;
                for (int j = 0; j <= NS; j++) m_hist[m][k][j] = 0;
            end
            m_valid[m] = 0;
            m_pulse[m] = 0;
            m_bus[m]   = 0;
            m_chan[m]  = 0;
            m_ptr[m]   = NC - 1;
            return;
        end
        for (int k = 0; k < NC; k++) begin
            sy = m_hist[m][k][NS-1];
            pv = m_hist[m][k][NS];
            evt[k] = (m == 1) ? int'(sy != pv) : int'(sy == 1 && pv == 0);
        end
        g = -1;
        m_pulse[m] = 0;
        if (m_valid[m] == 0 || rdy[m]) begin
            for (int i = 1; i <= NC; i++) begin
                c = (m_ptr[m] + i) % NC;
                if (g < 0 && m_pend[m][c] != 0) g = c;
            end
            if (g >= 0) begin
                m_bus[m]   = m_hold[m][g];
                m_chan[m]  = g;
                m_valid[m] = 1;
                m_pulse[m] = 1;
                m_pend[m][g] = 0;
                m_ptr[m]   = g;
            end else begin
                m_valid[m] = 0;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (clr[m][k]) m_ovr[m][k] = 0;
            if (evt[k] != 0) begin
                if (m_pend[m][k] != 0 && k != g) m_ovr[m][k] = 1;
                m_hold[m][k] = int'(bus[m][k*BW +: BW]);
                m_pend[m][k] = 1;
            end
        end
        for (int k = 0; k < NC; k++) begin
            for (int j = NS; j >= 1; j--) m_hist[m][k][j] = m_hist[m][k][j-1];
            m_hist[m][k][0] = int'(en[m][k]);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        int ep;
        int eo;
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                ep = 0;
                eo = 0;
                for (int k = 0; k < NC; k++) begin
                    ep |= m_pend[m][k] << k;
                    eo |= m_ovr[m][k] << k;
                end
                chk($sformatf("u%0d valid", m),   int'(valid[m]), m_valid[m]);
                chk($sformatf("u%0d pulse", m),   int'(pulse[m]), m_pulse[m]);
                chk($sformatf("u%0d bus", m),     int'(sb[m]),    m_bus[m]);
                chk($sformatf("u%0d chan", m),    int'(sc[m]),    m_chan[m]);
                chk($sformatf("u%0d pending", m), int'(pend[m]),  ep);
                chk($sformatf("u%0d overrun", m), int'(ovr[m]),   eo);
            end
        end
    end

    int q_chan[$];
    int q_bus[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic collect(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (pulse[m]) begin
                q_chan.push_back(int'(sc[m]));
                q_bus.push_back(int'(sb[m]));
            end
        end
    endtask

    task automatic chk_order(input string nm, input int ch[4], input int dv[4]);
        chk({nm, " count"}, q_chan.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_chan.size()) begin
                chk($sformatf("%s chan[%0d]", nm, i), q_chan[i], ch[i]);
                chk($sformatf("%s data[%0d]", nm, i), q_bus[i], dv[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; bus = '0; en = '0; clr = '0; rdy = 2'b00;
        tick();
        tick();
        started = 1;
        rst = 2'b00;
        tick();

        // Single event, level mode
        rdy[0] = 1'b1;
        bus[0][15:8] = 8'hA5;
        en[0][1] = 1'b1;
        tick();
        chk("lat e1 valid", int'(valid[0]), 0);
        tick();
        chk("lat e2 valid", int'(valid[0]), 0);
        tick();
        chk("lat e3 valid", int'(valid[0]), 0);
        chk("lat e3 pend1", int'(pend[0][1]), 1);
        tick();
        chk("lat e4 valid", int'(valid[0]), 1);
        chk("lat e4 bus", int'(sb[0]), 'hA5);
        chk("lat e4 chan", int'(sc[0]), 1);
        chk("lat e4 pulse", int'(pulse[0]), 1);
        chk("lat e4 pend1", int'(pend[0][1]), 0);
        tick();
        chk("lat e5 pulse", int'(pulse[0]), 0);
        chk("lat e5 valid", int'(valid[0]), 0);
        en[0][1] = 1'b0;

        // Contention from a fresh pointer
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        bus[0] = 32'h13121110;
        en[0] = 4'hF;
        q_chan.delete(); q_bus.delete();
        collect(0, 12);
        chk_order("burst1", '{0, 1, 2, 3}, '{'h10, 'h11, 'h12, 'h13});
        en[0] = 4'h0;
        collect(0, 4);
        bus[0][23:16] = 8'h22;
        en[0][2] = 1'b1;
        collect(0, 8);
        en[0] = 4'h0;
        collect(0, 4);
        q_chan.delete(); q_bus.delete();
        bus[0] = 32'h23222120;
        en[0] = 4'hF;
        collect(0, 12);
        chk_order("burst2", '{3, 0, 1, 2}, '{'h23, 'h20, 'h21, 'h22});

        // Backpressure
        en[0] = 4'h0;
        collect(0, 4);
        rdy[0] = 1'b0;
        bus[0][23:16] = 8'h3C;
        en[0][2] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp valid", int'(valid[0]), 1);
        chk("bp bus", int'(sb[0]), 'h3C);
        chk("bp chan", int'(sc[0]), 2);
        bus[0][15:8] = 8'h55;
        en[0][1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp hold bus", int'(sb[0]), 'h3C);
            chk("bp hold chan", int'(sc[0]), 2);
            chk("bp hold valid", int'(valid[0]), 1);
        end
        rdy[0] = 1'b1;
        tick();
        chk("bp next bus", int'(sb[0]), 'h55);
        chk("bp next chan", int'(sc[0]), 1);
        chk("bp next pulse", int'(pulse[0]), 1);
        tick();
        chk("bp drain valid", int'(valid[0]), 0);

        // Overrun
        en[0] = 4'h0;
        rdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus[0][31:24] = 8'h77;
        en[0][3] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ovr busy chan", int'(sc[0]), 3);
        bus[0][7:0] = 8'h01;
        en[0][0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("ovr first pend", int'(pend[0][0]), 1);
        chk("ovr first flag", int'(ovr[0][0]), 0);
        en[0][0] = 1'b0;
        tick();
        tick();
        bus[0][7:0] = 8'h02;
        en[0][0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("ovr flag", int'(ovr[0][0]), 1);
        rdy[0] = 1'b1;
        tick();
        chk("ovr data", int'(sb[0]), 'h02);
        chk("ovr chan", int'(sc[0]), 0);
        tick();
        chk("ovr sticky", int'(ovr[0][0]), 1);
        clr[0][0] = 1'b1;
        tick();
        clr[0][0] = 1'b0;
        chk("ovr cleared", int'(ovr[0][0]), 0);

        // Toggle mode
        rdy[1] = 1'b1;
        bus[1][31:24] = 8'h11;
        en[1][3] = 1'b1;
        q_chan.delete(); q_bus.delete();
        collect(1, 8);
        chk("tgl rise count", q_chan.size(), 1);
        q_chan.delete(); q_bus.delete();
        bus[1][31:24] = 8'h7E;
        en[1][3] = 1'b0;
        collect(1, 8);
        chk("tgl fall count", q_chan.size(), 1);
        if (q_chan.size() > 0) begin
            chk("tgl fall chan", q_chan[0], 3);
            chk("tgl fall data", q_bus[0], 'h7E);
        end

        // Reset while a toggle is inside the synchroniser
        bus[1][23:16] = 8'h99;
        en[1][2] = 1'b1;
        tick();
        rst[1] = 1'b1;
        en[1][2] = 1'b0;
        tick();
        chk("rst valid", int'(valid[1]), 0);
        chk("rst bus", int'(sb[1]), 0);
        chk("rst chan", int'(sc[1]), 0);
        chk("rst pulse", int'(pulse[1]), 0);
        chk("rst pend", int'(pend[1]), 0);
        rst[1] = 1'b0;
        q_chan.delete(); q_bus.delete();
        collect(1, 10);
        chk("rst no word", q_chan.size(), 0);
        chk("rst idle valid", int'(valid[1]), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
